// File: rtl/wb_stage_p.sv
// wb_stage_p: MEM/WB pipeline entry, load extraction/extension, register-file
// write port, one-cycle forwarding hold and misaligned-load detection.
// Optional: define WB_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module wb_stage_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              wite_reg_in,
  input  logic [ADDR_W-1:0] wite_reg_addr_in,
  input  logic              read_mem_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              wite_Rreg,
  output logic [ADDR_W-1:0] wite_Rreg_addr,
  output logic [DATA_W-1:0] wite_Rreg_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic [1:0]        size;
    logic              uns;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mdat;
  } entry_t;

  entry_t            e_q;
  logic              valid_q;
  logic              capture;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] byte_ext, half_ext, word_ext;
  logic [DATA_W-1:0] ld_data, wb_data;
  logic              err;

  assign in_ready = !stall;
  assign capture  = in_valid && in_ready && !flush;

  // Pipeline entry: every accepted instruction lives for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      e_q     <= '0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        e_q.wr   <= wite_reg_in;
        e_q.addr <= wite_reg_addr_in;
        e_q.rd   <= read_mem_in;
        e_q.size <= mem_size_in;
        e_q.uns  <= mem_unsigned_in;
        e_q.alu  <= alu_in;
        e_q.mdat <= mem_data_in;
      end
    end
  end

  // Low address bits select the byte lane inside the aligned memory word.
  assign off      = e_q.alu[OFF_W-1:0];
  assign sh       = e_q.mdat >> {off, 3'b000};
  assign byte_ext = {{(DATA_W-8){sh[7] & ~e_q.uns}}, sh[7:0]};
  assign half_ext = {{(DATA_W-16){sh[15] & ~e_q.uns}}, sh[15:0]};

  // A word load on a 32-bit datapath is already the full width.
  if (DATA_W == 64) begin : g_w64
    assign word_ext = {{(DATA_W-32){sh[31] & ~e_q.uns}}, sh[31:0]};
  end else begin : g_w32
    assign word_ext = sh;
  end

  // Size select; dword on a 32-bit datapath degenerates to the full word.
  always_comb begin
    ld_data = sh;
    case (e_q.size)
      2'b00:   ld_data = byte_ext;
      2'b01:   ld_data = half_ext;
      2'b10:   ld_data = word_ext;
      default: ld_data = sh;
    endcase
  end

  // Misalignment check only matters for load entries that are live.
  always_comb begin
    err = 1'b0;
    if (valid_q && e_q.rd) begin
      case (e_q.size)
        2'b01:   err = off[0];
        2'b10:   err = (off[1:0] != 2'b00);
        2'b11:   err = (off != '0);
        default: err = 1'b0;
      endcase
    end
  end

  assign wb_data      = e_q.rd ? ld_data : e_q.alu;
  assign misalign_err = err;
  assign wite_Rreg    = valid_q && e_q.wr && !err &&
                        !((ZERO_REG != 0) && (e_q.addr == '0));

  // fwd_* always holds the last written pair, so idle cycles replay it
  // on the write port instead of zeroing address/data.
  assign wite_Rreg_addr = wite_Rreg ? e_q.addr : fwd_addr;
  assign wite_Rreg_data = wite_Rreg ? wb_data  : fwd_data;

  // Forwarding hold: captures each register-file write for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= wite_Rreg;
      if (wite_Rreg) begin
        fwd_addr <= e_q.addr;
        fwd_data <= wb_data;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // Retire counter: every error-free live entry, write or not; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= '0;
    else if (valid_q && !err) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
